// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 word mux between four requesters.
// Select and grant are registered; out_data is the combinational mux output.

module mux4_1 (
  input  logic [1:0] s,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  output logic       y
);

  always_comb begin
    unique case (s)
      2'd0:    y = a;
      2'd1:    y = b;
      2'd2:    y = c;
      default: y = d;
    endcase
  end

endmodule

module mux4_rr_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [3:0]       lock,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       sel,
  output logic [3:0]       grant,
  output logic [3:0]       ack
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state, state_nx;
  logic [3:0] grant_nx;
  logic [1:0] sel_nx;
  logic [1:0] last, last_nx;
  logic [3:0] hold_cnt, hold_nx;
  logic       transfer;
  logic       keep_lock;
  logic [2:0] win_idle, win_xfer;

  // Returns {found, index}; the search starts just after 'from', so 'from' itself ranks last.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] from);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = from;
    for (int i = 1; i <= 4; i++) begin
      cand = from + 2'(i);
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  assign out_valid = (state == BUSY);
  assign transfer  = out_valid && out_ready;
  assign ack       = (rst && transfer) ? grant : 4'b0000;
  assign keep_lock = lock[sel] && req[sel] && (hold_cnt < 4'(MAX_HOLD));
  assign win_idle  = pick(req, last);
  assign win_xfer  = pick(req, sel);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    sel_nx   = sel;
    last_nx  = last;
    hold_nx  = hold_cnt;
    if (state == IDLE) begin
      if (win_idle[2]) begin
        state_nx = BUSY;
        sel_nx   = win_idle[1:0];
        grant_nx = 4'b0001 << win_idle[1:0];
        hold_nx  = 4'd1;
      end
    end else if (transfer) begin
      last_nx = sel;
      if (keep_lock) begin
        hold_nx = hold_cnt + 4'd1;
      end else if (((req & ~grant) != 4'b0000) || (lock[sel] && req[sel])) begin
        // Back-to-back handover; an exhausted lone locker wins its own slot again.
        sel_nx   = win_xfer[1:0];
        grant_nx = 4'b0001 << win_xfer[1:0];
        hold_nx  = 4'd1;
      end else begin
        state_nx = IDLE;
        grant_nx = 4'b0000;
        hold_nx  = 4'd0;
      end
    end else if (!req[sel]) begin
      state_nx = IDLE;
      grant_nx = 4'b0000;
      hold_nx  = 4'd0;
    end
  end

  // NOTE: state updates use non-blocking assignments; reset is sampled on the clock edge only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      grant    <= 4'b0000;
      sel      <= 2'd0;
      last     <= 2'd3;
      hold_cnt <= 4'd0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      sel      <= sel_nx;
      last     <= last_nx;
      hold_cnt <= hold_nx;
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_mux
    mux4_1 u_mux (
      .s(sel),
      .a(d0[b]),
      .b(d1[b]),
      .c(d2[b]),
      .d(d3[b]),
      .y(out_data[b])
    );
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: reset, rotation, stall, lock limit, abort, mid-transfer reset.

module tb_mux4_rr_arbiter;

  localparam logic [31:0] D0 = 32'hAAAA5555;
  localparam logic [31:0] D1 = 32'h11112222;
  localparam logic [31:0] D2 = 32'h3333CCCC;
  localparam logic [31:0] D3 = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] d0, d1, d2, d3;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  sel;
  logic [3:0]  grant;
  logic [3:0]  ack;

  int checks = 0;
  int errors = 0;

  mux4_rr_arbiter #(.WIDTH(32), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .sel(sel), .grant(grant), .ack(ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [1:0] s);
    case (s)
      2'd0:    return D0;
      2'd1:    return D1;
      2'd2:    return D2;
      default: return D3;
    endcase
  endfunction

  task automatic expect_out(input string tag, input logic v, input logic [3:0] g,
                            input logic [1:0] s, input logic [3:0] a);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".sel"},   32'(sel),   32'(s));
    check({tag, ".ack"},   32'(ack),   32'(a));
    check({tag, ".data"},  out_data,   word_of(s));
  endtask

  task automatic do_reset();
    rst = 1'b0; req = 4'b0000; lock = 4'b0000; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    d0 = D0; d1 = D1; d2 = D2; d3 = D3;

    // 1: reset state, single requester, ready with idle ignored
    rst = 1'b0; req = 4'b0000; lock = 4'b0000; out_ready = 1'b1;
    tick();
    tick();
    expect_out("reset", 1'b0, 4'b0000, 2'd0, 4'b0000);
    rst = 1'b1;
    #1;
    check("idle_ready_ignored.ack", 32'(ack), 32'h0);
    req = 4'b0001;
    #1;
    check("req_latency.valid", 32'(out_valid), 32'h0);
    tick();
    expect_out("single", 1'b1, 4'b0001, 2'd0, 4'b0001);
    tick();
    req = 4'b0000;
    expect_out("single_done", 1'b0, 4'b0000, 2'd0, 4'b0000);

    // 2: all four request, no lock: 0,1,2,3,0,1,2,3 back to back
    do_reset();
    req = 4'b1111; out_ready = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      expect_out($sformatf("rr%0d", i), 1'b1, 4'b0001 << (i % 4), 2'(i % 4), 4'b0001 << (i % 4));
      tick();
    end

    // 3: stall on requester 2; a new higher-priority req must not pre-empt
    do_reset();
    req = 4'b0100;
    tick();
    for (int i = 0; i < 5; i++) begin
      expect_out($sformatf("stall%0d", i), 1'b1, 4'b0100, 2'd2, 4'b0000);
      if (i == 2) req = 4'b0101;
      tick();
    end
    out_ready = 1'b1;
    #1;
    expect_out("stall_accept", 1'b1, 4'b0100, 2'd2, 4'b0100);
    tick();
    req = 4'b0001;
    expect_out("after_stall", 1'b1, 4'b0001, 2'd0, 4'b0001);

    // 4: locked requester 0 gets MAX_HOLD transfers, then 3, then 0 again
    do_reset();
    req = 4'b1001; lock = 4'b0001; out_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("lock%0d", i), 1'b1, 4'b0001, 2'd0, 4'b0001);
      tick();
    end
    expect_out("lock_rotate", 1'b1, 4'b1000, 2'd3, 4'b1000);
    tick();
    expect_out("lock_back", 1'b1, 4'b0001, 2'd0, 4'b0001);

    // 5: abort on requester 1 leaves last pointer at 0
    do_reset();
    req = 4'b0001; out_ready = 1'b1;
    tick();
    expect_out("abort_pre0", 1'b1, 4'b0001, 2'd0, 4'b0001);
    req = 4'b0011;
    tick();
    req = 4'b0000; out_ready = 1'b0;
    #1;
    expect_out("abort_busy", 1'b1, 4'b0010, 2'd1, 4'b0000);
    tick();
    expect_out("abort_idle", 1'b0, 4'b0000, 2'd1, 4'b0000);
    req = 4'b1111;
    tick();
    expect_out("abort_regrant", 1'b1, 4'b0010, 2'd1, 4'b0000);

    // 6: reset during a transfer drops it
    do_reset();
    req = 4'b1111; out_ready = 1'b1;
    tick();
    tick();
    expect_out("rst_busy", 1'b1, 4'b0010, 2'd1, 4'b0010);
    rst = 1'b0;
    #1;
    check("rst_mid.ack", 32'(ack), 32'h0);
    tick();
    expect_out("rst_mid", 1'b0, 4'b0000, 2'd0, 4'b0000);
    rst = 1'b1;
    tick();
    expect_out("rst_after", 1'b1, 4'b0001, 2'd0, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter that shares one 4:1 select datapath between four requesters and drives its select code.
- Each requester presents a WIDTH-bit word and a request.
- The arbiter picks one requester, holds the select stable until the downstream consumer accepts the word, then rotates priority.
- The datapath is built from per-bit mux4_1 instances driven by the registered select. It sits in front of shared single-port resources in the MIPS datapath, e.g. a write-back bus.

Parameters:
WIDTH, 32, data word width per requester
MAX_HOLD, 4, max consecutive transfers one locked requester may take before forced rotation (1..15)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
req  in  4  request per requester; must stay high until acked
lock  in  4  per-requester burst lock; keep grant across transfers
d0  in  WIDTH  requester 0 data
d1  in  WIDTH  requester 1 data
d2  in  WIDTH  requester 2 data
d3  in  WIDTH  requester 3 data
out_ready  in  1  downstream accepts word this cycle
out_valid  out  1  selected word valid
out_data  out  WIDTH  selected word, equal to d[sel]
sel  out  2  registered select code to the mux
grant  out  4  one-hot registered grant; all zero when idle
ack  out  4  grant AND (out_valid AND out_ready); combinational; one-hot transfer strobe

Behaviour:
Reset: clk edge with rst=0 gives:
- grant=0, sel=0, out_valid=0, hold_cnt=0
- last pointer=3, so requester 0 has top priority first
- Reset mid-transfer drops the transfer; no ack that cycle.

Datapath:
- out_data = d[sel] combinationally from the registered sel; no data register.
- sel always equals the index of the set grant bit; it keeps its last value when idle.

Priority search:
- Starts at last+1 mod 4 and wraps.
- The current or last owner has the lowest priority.

State IDLE (out_valid=0):
- If any req bit is set, the next edge loads grant/sel with the winner, sets out_valid=1, hold_cnt=1, and moves to BUSY.
- Latency is one cycle from req to out_valid.

State BUSY (out_valid=1):
- If out_valid & out_ready, a transfer occurs; ack[sel]=1 that cycle and last <= sel.
  - If lock[sel] & req[sel] & hold_cnt<MAX_HOLD: keep grant, hold_cnt+1.
  - Else if any other req, or req[sel] with lock exhausted: grant the next winner back-to-back with no idle bubble; hold_cnt=1.
  - A lone requester whose lock is exhausted is re-granted (no starvation of others possible).
  - Else go to IDLE.
- If no transfer and req[sel]=1: hold everything; sel and grant stay stable.
- If no transfer and req[sel]=0 (protocol abort): go to IDLE next edge; last is unchanged; no ack.

Boundaries:
- out_ready with out_valid=0 is ignored.
- Simultaneous requests from all four, with no lock, are served 0,1,2,3,0... one per accepted transfer.
- New req arriving while BUSY does not pre-empt.
- lock changes are sampled only at transfer edges.
- ack is never asserted for more than one bit; grant is never multi-hot.

Test Plan:
1. Reset then req=0001, d0=0xAAAA5555, out_ready=1 → out_valid=1 one cycle after req; sel=0, out_data=0xAAAA5555, ack=0001; idle next cycle after req drops.
2. req=1111, lock=0, out_ready=1 for 8 cycles → sel sequence 0,1,2,3,0,1,2,3 with back-to-back acks, no bubble.
3. Granted requester 2 with out_ready=0 for 5 cycles → sel=2, grant=0100, out_data=d2 stable, ack=0; accepted on 6th cycle.
4. MAX_HOLD=4, req=1001, lock=0001, out_ready=1 → four consecutive acks to 0, then grant=1000, then back to 0.
5. BUSY on requester 1, req[1] dropped without out_ready → out_valid=0 next cycle, no ack; next req=1111 grants requester 1 again (last unchanged).
6. rst=0 asserted during BUSY with out_ready=1 → following edge grant=0, out_valid=0, sel=0; after release req=1111 grants 0 first.
